// File: rtl/resp_pkg.sv
// Shared constants and state encoding for the host response serializer.
package resp_pkg;

   // Host command codes echoed back in ACK replies or answered with a MATCH reply
   localparam logic [7:0] CMD_SET_HASH   = 8'h01;
   localparam logic [7:0] CMD_SEND_STR   = 8'h02;
   localparam logic [7:0] CMD_READ_MATCH = 8'h03;

   localparam int unsigned MATCH_BYTES_DEF = 19;
   localparam int unsigned POS_BYTES_DEF   = 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StGap  = 2'd2,
      StWait = 2'd3
   } state_e;

endpackage

// File: rtl/resp_tx.sv
// Response serializer: turns ACK / MATCH replies into a paced byte stream toward uart_tx.
// A reply is loaded into a left-shifting buffer and emitted top byte first, one
// txd_start strobe per byte, waiting for txd_busy to clear before each byte.
module resp_tx
   import resp_pkg::*;
#(
   parameter int unsigned MATCH_BYTES = MATCH_BYTES_DEF,
   parameter int unsigned POS_BYTES   = POS_BYTES_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ack_start,
   input  logic [7:0]               ack_code,
   input  logic                     match_start,
   input  logic [15:0]              match_pos,
   input  logic [MATCH_BYTES*8-1:0] match_str,
   input  logic                     txd_busy,
   output logic                     txd_start,
   output logic [7:0]               txd_data,
   output logic                     busy,
   output logic                     done,
   output logic                     req_drop
);

   localparam int unsigned NUM_BYTES = POS_BYTES + MATCH_BYTES;
   localparam int unsigned BUF_W     = NUM_BYTES * 8;
   localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);

   state_e                 state_q, state_d;
   logic [BUF_W-1:0]       buf_q, buf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   txd_start_q, txd_start_d;
   logic [7:0]             txd_data_q, txd_data_d;
   logic                   done_q, done_d;
   logic                   req_drop_q, req_drop_d;

   // State and registered outputs; synchronous reset aborts any reply in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         buf_q       <= '0;
         cnt_q       <= '0;
         txd_start_q <= 1'b0;
         txd_data_q  <= 8'h00;
         done_q      <= 1'b0;
         req_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         txd_start_q <= txd_start_d;
         txd_data_q  <= txd_data_d;
         done_q      <= done_d;
         req_drop_q  <= req_drop_d;
      end
   end

   // Next-state: request acceptance, byte emission and txd_busy pacing
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      txd_start_d = 1'b0;
      txd_data_d  = txd_data_q;
      done_d      = 1'b0;
      req_drop_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (done_q) begin
               // Completion cycle still counts as part of the finished reply
               req_drop_d = ack_start | match_start;
            end else if (match_start) begin
               buf_d      = BUF_W'({match_pos, match_str});
               cnt_d      = CNT_W'(NUM_BYTES);
               state_d    = StSend;
               req_drop_d = ack_start;
            end else if (ack_start) begin
               buf_d   = {ack_code, {(BUF_W-8){1'b0}}};
               cnt_d   = CNT_W'(1);
               state_d = StSend;
            end
         end
         StSend: begin
            req_drop_d = ack_start | match_start;
            if (!txd_busy) begin
               txd_start_d = 1'b1;
               txd_data_d  = buf_q[BUF_W-1 -: 8];
               buf_d       = {buf_q[BUF_W-9:0], 8'h00};
               cnt_d       = cnt_q - CNT_W'(1);
               state_d     = StGap;
            end
         end
         StGap: begin
            // One idle cycle lets uart_tx raise txd_busy before we look at it
            req_drop_d = ack_start | match_start;
            state_d    = StWait;
         end
         StWait: begin
            req_drop_d = ack_start | match_start;
            if (!txd_busy) begin
               if (cnt_q != '0) begin
                  state_d = StSend;
               end else begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
      endcase
   end

   assign txd_start = txd_start_q;
   assign txd_data  = txd_data_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign req_drop  = req_drop_q;

endmodule

// File: tb/tb_resp_tx.sv
// Self-checking bench for resp_tx: directed scenarios with randomized payloads and
// uart_tx busy lengths, checked against a byte-list reference model.
module tb_resp_tx;

   localparam int unsigned MB = 19;
   localparam int unsigned NB = MB + 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            ack_start = 1'b0;
   logic [7:0]      ack_code = 8'h00;
   logic            match_start = 1'b0;
   logic [15:0]     match_pos = 16'h0000;
   logic [MB*8-1:0] match_str = '0;
   logic            txd_busy = 1'b0;
   logic            txd_start;
   logic [7:0]      txd_data;
   logic            busy;
   logic            done;
   logic            req_drop;

   resp_tx #(.MATCH_BYTES(MB), .POS_BYTES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .ack_start   (ack_start),
      .ack_code    (ack_code),
      .match_start (match_start),
      .match_pos   (match_pos),
      .match_str   (match_str),
      .txd_busy    (txd_busy),
      .txd_start   (txd_start),
      .txd_data    (txd_data),
      .busy        (busy),
      .done        (done),
      .req_drop    (req_drop)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // uart_tx model: busy for busy_len cycles after each strobe, or held by force_busy
   int busy_len = 10;
   bit force_busy = 1'b0;
   int ucnt = 0;
   always @(posedge clk) begin
      #2;
      txd_busy = force_busy || (ucnt > 0);
      if (ucnt > 0) ucnt--;
      if (txd_start === 1'b1) ucnt = busy_len;
   end

   // Monitor: records strobed bytes, their cycles and spacing; counts done/req_drop pulses
   logic [7:0] obs_q[$];
   int         scyc_q[$];
   int         gap_q[$];
   int         last_cyc = 0;
   bit         have_last = 1'b0;
   int         done_seen = 0;
   int         drop_seen = 0;
   always @(negedge clk) begin
      bit ok;
      if (done === 1'b1) done_seen++;
      if (req_drop === 1'b1) drop_seen++;
      if (txd_start === 1'b1) begin
         if (have_last) begin
            gap_q.push_back(cyc - last_cyc);
            ok = (cyc - last_cyc) >= 3;
            check("strobe_spacing", 32'(ok), 32'd1);
         end
         obs_q.push_back(txd_data);
         scyc_q.push_back(cyc);
         last_cyc  = cyc;
         have_last = 1'b1;
      end
   end

   // Reference model: the reply is simply the ordered list of bytes to be sent
   logic [7:0] exp_q[$];

   function automatic void model_match(input logic [15:0] pos, input logic [MB*8-1:0] str);
      logic [MB*8-1:0] sh;
      exp_q.delete();
      exp_q.push_back(pos[15:8]);
      exp_q.push_back(pos[7:0]);
      for (int i = 0; i < MB; i++) begin
         sh = str >> (8 * (MB - 1 - i));
         exp_q.push_back(sh[7:0]);
      end
   endfunction

   function automatic void model_ack(input logic [7:0] code);
      exp_q.delete();
      exp_q.push_back(code);
   endfunction

   function automatic logic [MB*8-1:0] rand_str();
      logic [MB*8-1:0] s;
      s = '0;
      for (int i = 0; i < MB; i++) s = {s[MB*8-9:0], 8'($urandom_range(0, 255))};
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_q.delete();
      scyc_q.delete();
      gap_q.delete();
      have_last = 1'b0;
      done_seen = 0;
      drop_seen = 0;
   endtask

   task automatic do_match(input logic [15:0] pos, input logic [MB*8-1:0] str, output int rc);
      match_pos   = pos;
      match_str   = str;
      match_start = 1'b1;
      rc          = cyc;
      tick();
      match_start = 1'b0;
   endtask

   task automatic do_ack(input logic [7:0] code, output int rc);
      ack_code  = code;
      ack_start = 1'b1;
      rc        = cyc;
      tick();
      ack_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int i;
      i = 0;
      while (done_seen == 0 && i < budget) begin
         tick();
         i++;
      end
      check({tag, "_done_timeout"}, 32'(done_seen > 0), 32'd1);
      repeat (4) tick();
   endtask

   task automatic compare_reply(input string tag);
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs_q.size())
            check($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
         else
            check($sformatf("%s_byte%0d_missing", tag, i), 32'd0, 32'd1);
      end
      check({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_txd_start"}, 32'(txd_start), 32'd0);
      check({tag, "_txd_data"}, 32'(txd_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_req_drop"}, 32'(req_drop), 32'd0);
   endtask

   initial begin
      int              rc, r, n, i;
      logic [15:0]     p;
      logic [MB*8-1:0] s;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

      // 1. Single ACK byte with a 10-cycle uart busy period
      busy_len = 10;
      clear_obs();
      model_ack(8'h01);
      do_ack(8'h01, rc);
      wait_done(200, "ack");
      compare_reply("ack");
      if (scyc_q.size() > 0) check("ack_latency", 32'(scyc_q[0] - rc), 32'd2);
      check("ack_busy_after", 32'(busy), 32'd0);

      // 2. MATCH reply with the fixed string
      busy_len = $urandom_range(0, 12);
      clear_obs();
      s = 152'h54686520_71756963_6b206272_6f776e20_666f78;
      model_match(16'h0007, s);
      do_match(16'h0007, s, rc);
      wait_done(2000, "match");
      compare_reply("match");
      if (scyc_q.size() > 0) check("match_latency", 32'(scyc_q[0] - rc), 32'd2);

      // 3. Pacing: hold txd_busy high, then release with a uart that never raises busy
      busy_len   = 0;
      force_busy = 1'b1;
      tick();
      clear_obs();
      p = 16'($urandom);
      s = rand_str();
      model_match(p, s);
      do_match(p, s, rc);
      repeat (200) tick();
      check("pace_hold_nostrobe", 32'(obs_q.size()), 32'd0);
      check("pace_hold_busy", 32'(busy), 32'd1);
      force_busy = 1'b0;
      r = cyc;
      wait_done(2000, "pace");
      compare_reply("pace");
      if (scyc_q.size() > 0) check("pace_release_latency", 32'(scyc_q[0] - r), 32'd1);
      for (int k = 0; k < gap_q.size(); k++)
         check($sformatf("pace_gap%0d", k), 32'(gap_q[k]), 32'd3);

      // 4a. ACK and MATCH together: MATCH wins, ACK dropped
      busy_len = $urandom_range(0, 8);
      clear_obs();
      p = 16'($urandom);
      s = rand_str();
      model_match(p, s);
      ack_code  = 8'h02;
      ack_start = 1'b1;
      do_match(p, s, rc);
      ack_start = 1'b0;
      wait_done(2000, "collide");
      compare_reply("collide");
      check("collide_drops", 32'(drop_seen), 32'd1);

      // 4b. ACK arriving mid-reply is dropped and leaves the stream intact
      busy_len = $urandom_range(0, 8);
      clear_obs();
      p = 16'($urandom);
      s = rand_str();
      model_match(p, s);
      do_match(p, s, rc);
      i = 0;
      while (obs_q.size() < 3 && i < 500) begin
         tick();
         i++;
      end
      check("midack_reach3", 32'(obs_q.size() >= 3), 32'd1);
      do_ack(8'h55, rc);
      wait_done(2000, "midack");
      compare_reply("midack");
      check("midack_drops", 32'(drop_seen), 32'd1);

      // 4c. Request in the same cycle as done is dropped
      busy_len = $urandom_range(0, 8);
      clear_obs();
      do_ack(8'h01, rc);
      i = 0;
      while (done !== 1'b1 && i < 200) begin
         tick();
         i++;
      end
      check("donecoll_saw_done", 32'(done), 32'd1);
      ack_code    = 8'h02;
      ack_start   = 1'b1;
      match_start = 1'b1;
      tick();
      ack_start   = 1'b0;
      match_start = 1'b0;
      repeat (40) tick();
      check("donecoll_strobes", 32'(obs_q.size()), 32'd1);
      check("donecoll_drops", 32'(drop_seen), 32'd1);
      check("donecoll_busy", 32'(busy), 32'd0);

      // 5. Reset right after the 5th strobe of a MATCH reply
      busy_len = $urandom_range(0, 6);
      clear_obs();
      p = 16'($urandom);
      s = rand_str();
      do_match(p, s, rc);
      n = 0;
      i = 0;
      while (n < 5 && i < 2000) begin
         tick();
         i++;
         if (txd_start === 1'b1) n++;
      end
      check("rst_reach5", 32'(n), 32'd5);
      reset = 1'b1;
      tick();
      check_reset_outputs("rst_mid");
      tick();
      reset = 1'b0;
      repeat (80) tick();
      check("rst_no_more_strobes", 32'(obs_q.size()), 32'd5);
      check("rst_idle_busy", 32'(busy), 32'd0);
      clear_obs();
      model_ack(8'h02);
      do_ack(8'h02, rc);
      wait_done(200, "rst_ack");
      compare_reply("rst_ack");

      // 6. Inputs changing every cycle after acceptance do not affect the reply
      busy_len = $urandom_range(0, 8);
      clear_obs();
      p = 16'($urandom);
      s = rand_str();
      model_match(p, s);
      do_match(p, s, rc);
      i = 0;
      while (done_seen == 0 && i < 2000) begin
         match_str = rand_str();
         match_pos = 16'($urandom);
         tick();
         i++;
      end
      wait_done(10, "stable");
      compare_reply("stable");

      // Random mix of replies
      for (int t = 0; t < 4; t++) begin
         busy_len = $urandom_range(0, 12);
         clear_obs();
         if ($urandom_range(0, 1) == 1) begin
            p = 16'($urandom);
            s = rand_str();
            model_match(p, s);
            do_match(p, s, rc);
         end else begin
            p = 16'($urandom_range(1, 2));
            model_ack(p[7:0]);
            do_ack(p[7:0], rc);
         end
         wait_done(2000, $sformatf("rand%0d", t));
         compare_reply($sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/resp_tx.md
Name: resp_tx

Overview:
- Response serializer on the FPGA side of the host command protocol. Converts the parser's replies into the byte stream toward uart_tx, one txd_start strobe per byte.
- Reply types:
  - ACK reply: 1 byte, the echoed command code, for cmds 0x01 and 0x02.
  - MATCH reply: for cmd 0x03. Sends match_pos (2 bytes, MSB first), then match_str (MATCH_BYTES bytes, first character first).
- Sits between cmd_parser/string_process_match and uart_tx, and paces all output on txd_busy.

Parameters:
- MATCH_BYTES, 19, number of matched-string bytes sent after byte_pos.
- POS_BYTES, 2, width of byte_pos in bytes. Fixed at 2; the parameter exists only for buffer sizing.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ack_start  in  1  one-cycle request to send an ACK byte
- ack_code  in  8  ACK byte, sampled with ack_start
- match_start  in  1  one-cycle request to send a MATCH reply
- match_pos  in  16  match byte position, sampled with match_start
- match_str  in  MATCH_BYTES*8  matched text; byte 0 is in the MSBs; sampled with match_start
- txd_busy  in  1  uart_tx busy
- txd_start  out  1  one-cycle byte-send strobe to uart_tx
- txd_data  out  8  byte to send; valid while txd_start=1
- busy  out  1  high from the cycle after acceptance until reply completion
- done  out  1  one-cycle pulse after the last byte's txd_busy falls
- req_drop  out  1  one-cycle pulse when a request is ignored

Behaviour:
- Reset: state=IDLE, txd_start=0, txd_data=0, busy=0, done=0, req_drop=0, byte count=0, shift buffer=0. Reset mid-reply aborts immediately; no further txd_start is issued.
- Buffer: shift register of (POS_BYTES+MATCH_BYTES)*8 bits. The byte sent is always the top 8 bits; after each strobe the buffer shifts left by 8 with zero fill.
- Counter: width ceil(log2(POS_BYTES+MATCH_BYTES+1)). Holds the number of bytes remaining.
- IDLE:
  - match_start=1 → load {match_pos, match_str}, count=POS_BYTES+MATCH_BYTES, go to SEND.
  - else ack_start=1 → load ack_code into the top byte, count=1, go to SEND.
  - Both asserted → MATCH is accepted and ACK is dropped; req_drop pulses the next cycle.
- SEND:
  - txd_busy=1 → wait.
  - txd_busy=0 → next cycle txd_start=1 with txd_data=top byte; shift; count−1; go to GAP.
- GAP: exactly 1 cycle, so uart_tx can raise txd_busy. txd_start=0. Go to WAIT.
- WAIT:
  - txd_busy=1 → wait.
  - txd_busy=0 and count≠0 → go to SEND.
  - txd_busy=0 and count=0 → done=1 for one cycle, go to IDLE.
- Latency and spacing:
  - With txd_busy=0, the first txd_start is asserted 2 cycles after the request cycle.
  - The minimum spacing between txd_start strobes is 3 cycles (SEND→GAP→WAIT) even if uart_tx never raises txd_busy.
- txd_start is never asserted on two consecutive cycles.
- txd_data holds its value between strobes.
- Requests while not in IDLE (busy=1) are ignored and pulse req_drop. A request in the same cycle as done is also dropped.
- Input values are used only at acceptance; later changes to match_pos or match_str do not affect a reply in progress.
- txd_busy stuck high: the block waits indefinitely. There is no timeout.

Decomposition:
- Shared package resp_pkg:
  - CMD_SET_HASH=8'h01, CMD_SEND_STR=8'h02, CMD_READ_MATCH=8'h03
  - MATCH_BYTES_DEF=19, POS_BYTES_DEF=2
  - state encodings IDLE/SEND/GAP/WAIT
- Single module; no sub-module needed. The txd_busy pacing is small enough to stay inline.

Test Plan:
1. ACK: reset, then ack_start with ack_code=8'h01. Model uart_tx as busy for 10 cycles after each strobe. Expect exactly one txd_start with txd_data=8'h01, then done one pulse later; busy=0 afterward.
2. MATCH: match_start with match_pos=16'h0007 and match_str="The quick brown fox" (152'h54686520_71756963_6b206272_6f776e20_666f78). Expect 21 strobes in order 00,07,54,68,65,…,66,6f,78; exactly one done pulse; strobe count checked equals 21.
3. Pacing: hold txd_busy=1 for 200 cycles with a MATCH request pending. Expect no txd_start during that time. After release, the first strobe occurs 1 cycle after txd_busy falls, and no strobes are ever back to back.
4. Collision:
   - ack_start and match_start in the same cycle → a MATCH reply is sent and req_drop pulses once.
   - ack_start mid-reply → req_drop pulses and the reply stream is unaltered.
5. Reset mid-reply: assert reset after the 5th strobe of a MATCH reply. Expect outputs at reset values and no further strobes. A subsequent ACK 8'h02 is sent correctly as a single byte.
6. Input stability: change match_str every cycle after acceptance. Expect the transmitted bytes to equal the values captured at acceptance.
